// File: rtl/liang_pkg.sv
// Shared types and constants for the liang core; the LSU state, request and
// response types and the AXI OKAY code live here alongside the memory-op enums.
package liang_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LH   = 3'd2,
        LOAD_LW   = 3'd3,
        LOAD_LD   = 3'd4,
        LOAD_LBU  = 3'd5,
        LOAD_LHU  = 3'd6,
        LOAD_LWU  = 3'd7
    } load_type_e;

    typedef enum logic [2:0] {
        STORE_NONE = 3'd0,
        STORE_SB   = 3'd1,
        STORE_SH   = 3'd2,
        STORE_SW   = 3'd3,
        STORE_SD   = 3'd4
    } store_type_e;

    typedef enum logic [2:0] {
        LSU_IDLE    = 3'd0,
        LSU_RD_ADDR = 3'd1,
        LSU_RD_DATA = 3'd2,
        LSU_WR      = 3'd3,
        LSU_WR_RESP = 3'd4,
        LSU_RESP    = 3'd5
    } lsu_state_e;

    typedef struct packed {
        load_type_e              load_type;
        store_type_e             store_type;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   wdata;
    } lsu_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic                    err;
    } lsu_resp_t;

    // Loads win over stores when both are set, so only the winning type is judged.
    function automatic logic is_misaligned(load_type_e lt, store_type_e st, logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (lt != LOAD_NONE) begin
            case (lt)
                LOAD_LH, LOAD_LHU:          bad = off[0];
                LOAD_LW, LOAD_LD, LOAD_LWU: bad = (off != 2'b00);
                default:                    bad = 1'b0;
            endcase
        end else begin
            case (st)
                STORE_SH:           bad = off[0];
                STORE_SW, STORE_SD: bad = (off != 2'b00);
                default:            bad = 1'b0;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/liang_lsu_align.sv
// Byte-lane steering for the LSU: read data extract/extend and store data/strobe
// placement. Lanes pushed past byte 3 are dropped, never wrapped.
module liang_lsu_align
    import liang_pkg::*;
(
    input  load_type_e              load_type,
    input  store_type_e             store_type,
    input  logic [1:0]              offset,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   ld_data,
    output logic [DATA_WIDTH-1:0]   st_wdata,
    output logic [STRB_WIDTH-1:0]   st_wstrb
);

    localparam logic [STRB_WIDTH-1:0] STRB_BYTE = STRB_WIDTH'(1);
    localparam logic [STRB_WIDTH-1:0] STRB_HALF = STRB_WIDTH'(3);

    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] rd_shift;

    always_comb begin
        shamt    = {offset, 3'b000};
        rd_shift = rdata >> shamt;
        ld_data  = rd_shift;
        case (load_type)
            LOAD_LB:  ld_data = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
            LOAD_LBU: ld_data = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
            LOAD_LH:  ld_data = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
            LOAD_LHU: ld_data = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
            default:  ld_data = rd_shift;
        endcase

        st_wdata = wdata << shamt;
        case (store_type)
            STORE_SB:           st_wstrb = STRB_BYTE << offset;
            STORE_SH:           st_wstrb = STRB_HALF << offset;
            STORE_SW, STORE_SD: st_wstrb = '1;
            default:            st_wstrb = '0;
        endcase
    end

endmodule

// File: rtl/liang_lsu.sv
// EX-stage load/store unit: one uop at a time over an AXI4-Lite master port.
// Build option LIANG_LSU_MISALIGN_CHK_EN: misaligned H/W accesses fail in IDLE with no bus traffic.
//
// state    | meaning
// IDLE     | ready for a uop; latches type, address and store data on req_valid_i
// RD_ADDR  | AR presented, waiting for arready
// RD_DATA  | rready high, waiting for read data
// WR       | AW and W presented, each dropped after its own handshake
// WR_RESP  | bready high, waiting for write response
// RESP     | result held on resp_* until WB accepts it
module liang_lsu
    import liang_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [2:0]              req_load_type_i,
    input  logic [2:0]              req_store_type_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DATA_WIDTH-1:0]   resp_data_o,
    output logic                    resp_err_o,
    output logic [ADDR_WIDTH-1:0]   m_araddr_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [1:0]              m_rresp_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o,
    output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [STRB_WIDTH-1:0]   m_wstrb_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    input  logic [1:0]              m_bresp_i,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o
);

    lsu_state_e            state, state_next;
    lsu_req_t              req;
    lsu_resp_t             resp;
    logic                  aw_done, w_done;
    load_type_e            in_load;
    store_type_e           in_store;
    logic                  in_misaligned;
    logic [DATA_WIDTH-1:0] ld_data;

    assign in_load  = load_type_e'(req_load_type_i);
    assign in_store = store_type_e'(req_store_type_i);

`ifdef LIANG_LSU_MISALIGN_CHK_EN
    assign in_misaligned = is_misaligned(in_load, in_store, req_addr_i[1:0]);
`else
    assign in_misaligned = 1'b0;
`endif

    liang_lsu_align u_align (
        .load_type  (req.load_type),
        .store_type (req.store_type),
        .offset     (req.addr[1:0]),
        .rdata      (m_rdata_i),
        .wdata      (req.wdata),
        .ld_data    (ld_data),
        .st_wdata   (m_wdata_o),
        .st_wstrb   (m_wstrb_o)
    );

    assign m_araddr_o  = {req.addr[ADDR_WIDTH-1:2], 2'b00};
    assign m_awaddr_o  = {req.addr[ADDR_WIDTH-1:2], 2'b00};
    assign resp_data_o = resp.data;
    assign resp_err_o  = resp.err;

    always_comb begin
        state_next   = state;
        req_ready_o  = 1'b0;
        m_arvalid_o  = 1'b0;
        m_rready_o   = 1'b0;
        m_awvalid_o  = 1'b0;
        m_wvalid_o   = 1'b0;
        m_bready_o   = 1'b0;
        resp_valid_o = 1'b0;
        case (state)
            LSU_IDLE: begin
                // Held low while reset is asserted so nothing looks acceptable then.
                req_ready_o = rst_n;
                if (req_valid_i) begin
                    if (in_misaligned)
                        state_next = LSU_RESP;
                    else if (in_load != LOAD_NONE)
                        state_next = LSU_RD_ADDR;
                    else if (in_store != STORE_NONE)
                        state_next = LSU_WR;
                    else
                        state_next = LSU_RESP;
                end
            end
            LSU_RD_ADDR: begin
                m_arvalid_o = 1'b1;
                if (m_arready_i)
                    state_next = LSU_RD_DATA;
            end
            LSU_RD_DATA: begin
                m_rready_o = 1'b1;
                if (m_rvalid_i)
                    state_next = LSU_RESP;
            end
            LSU_WR: begin
                m_awvalid_o = !aw_done;
                m_wvalid_o  = !w_done;
                if ((aw_done || m_awready_i) && (w_done || m_wready_i))
                    state_next = LSU_WR_RESP;
            end
            LSU_WR_RESP: begin
                m_bready_o = 1'b1;
                if (m_bvalid_i)
                    state_next = LSU_RESP;
            end
            LSU_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i)
                    state_next = LSU_IDLE;
            end
            default: state_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= LSU_IDLE;
            req     <= '0;
            resp    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                LSU_IDLE: begin
                    if (req_valid_i) begin
                        req.load_type  <= in_load;
                        req.store_type <= in_store;
                        req.addr       <= req_addr_i;
                        req.wdata      <= req_wdata_i;
                        aw_done        <= 1'b0;
                        w_done         <= 1'b0;
                        resp.data      <= '0;
                        resp.err       <= in_misaligned;
                    end
                end
                LSU_RD_DATA: begin
                    if (m_rvalid_i) begin
                        resp.data <= ld_data;
                        resp.err  <= (m_rresp_i != AXI_RESP_OKAY);
                    end
                end
                LSU_WR: begin
                    if (m_awready_i)
                        aw_done <= 1'b1;
                    if (m_wready_i)
                        w_done <= 1'b1;
                end
                LSU_WR_RESP: begin
                    if (m_bvalid_i) begin
                        resp.data <= '0;
                        resp.err  <= (m_bresp_i != AXI_RESP_OKAY);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_liang_lsu.sv
// Self-checking bench for liang_lsu: vector table driven through a cycle-stepped
// AXI-Lite slave, results checked through an expected-response queue.
module tb_liang_lsu;
    import liang_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_load_type_i;
    logic [2:0]  req_store_type_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic [31:0] m_araddr_o;
    logic        m_arvalid_o;
    logic        m_arready_i;
    logic [31:0] m_rdata_i;
    logic [1:0]  m_rresp_i;
    logic        m_rvalid_i;
    logic        m_rready_o;
    logic [31:0] m_awaddr_o;
    logic        m_awvalid_o;
    logic        m_awready_i;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic        m_wvalid_o;
    logic        m_wready_i;
    logic [1:0]  m_bresp_i;
    logic        m_bvalid_i;
    logic        m_bready_o;

    always #5 clk = ~clk;

    liang_lsu dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_load_type_i  (req_load_type_i),
        .req_store_type_i (req_store_type_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_data_o      (resp_data_o),
        .resp_err_o       (resp_err_o),
        .m_araddr_o       (m_araddr_o),
        .m_arvalid_o      (m_arvalid_o),
        .m_arready_i      (m_arready_i),
        .m_rdata_i        (m_rdata_i),
        .m_rresp_i        (m_rresp_i),
        .m_rvalid_i       (m_rvalid_i),
        .m_rready_o       (m_rready_o),
        .m_awaddr_o       (m_awaddr_o),
        .m_awvalid_o      (m_awvalid_o),
        .m_awready_i      (m_awready_i),
        .m_wdata_o        (m_wdata_o),
        .m_wstrb_o        (m_wstrb_o),
        .m_wvalid_o       (m_wvalid_o),
        .m_wready_i       (m_wready_i),
        .m_bresp_i        (m_bresp_i),
        .m_bvalid_i       (m_bvalid_i),
        .m_bready_o       (m_bready_o)
    );

    typedef struct {
        logic [2:0]  lt;
        logic [2:0]  st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [1:0]  bresp;
        int          ar_wait;
        int          aw_wait;
        int          w_wait;
        int          rr_wait;
        bit          exp_rd;
        bit          exp_wr;
        logic [31:0] exp_bus_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t      vecs[$];
    lsu_resp_t exp_q[$];
    int        n_checks = 0;
    int        n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t rd_vec(input logic [2:0] lt, input logic [2:0] st, input logic [31:0] addr,
                                    input logic [31:0] rdata, input logic [1:0] rresp, input int ar_wait,
                                    input int rr_wait, input logic [31:0] data, input logic err);
        vec_t v;
        v = '{lt: lt, st: st, addr: addr, wdata: 32'h0, rdata: rdata, rresp: rresp, bresp: 2'b00,
              ar_wait: ar_wait, aw_wait: 0, w_wait: 0, rr_wait: rr_wait, exp_rd: 1'b1, exp_wr: 1'b0,
              exp_bus_addr: {addr[31:2], 2'b00}, exp_wdata: 32'h0, exp_wstrb: 4'h0,
              exp_data: data, exp_err: err, exp_lat: (ar_wait == 0) ? 3 : 0};
        return v;
    endfunction

    function automatic vec_t wr_vec(input logic [2:0] st, input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [1:0] bresp, input int aw_wait, input int w_wait,
                                    input logic [31:0] exp_wdata, input logic [3:0] strb, input logic err);
        vec_t v;
        v = '{lt: LOAD_NONE, st: st, addr: addr, wdata: wdata, rdata: 32'h0, rresp: 2'b00, bresp: bresp,
              ar_wait: 0, aw_wait: aw_wait, w_wait: w_wait, rr_wait: 0, exp_rd: 1'b0, exp_wr: 1'b1,
              exp_bus_addr: {addr[31:2], 2'b00}, exp_wdata: exp_wdata, exp_wstrb: strb,
              exp_data: 32'h0, exp_err: err, exp_lat: (aw_wait == 0 && w_wait == 0) ? 3 : 0};
        return v;
    endfunction

    function automatic vec_t nobus_vec(input logic [2:0] lt, input logic [2:0] st, input logic [31:0] addr,
                                       input logic err);
        vec_t v;
        v = '{lt: lt, st: st, addr: addr, wdata: 32'h5A5A5A5A, rdata: 32'h0, rresp: 2'b00, bresp: 2'b00,
              ar_wait: 0, aw_wait: 0, w_wait: 0, rr_wait: 0, exp_rd: 1'b0, exp_wr: 1'b0,
              exp_bus_addr: 32'h0, exp_wdata: 32'h0, exp_wstrb: 4'h0,
              exp_data: 32'h0, exp_err: err, exp_lat: 1};
        return v;
    endfunction

    task automatic clear_slave();
        m_arready_i  = 1'b0;
        m_rvalid_i   = 1'b0;
        m_rdata_i    = 32'h0;
        m_rresp_i    = 2'b00;
        m_awready_i  = 1'b0;
        m_wready_i   = 1'b0;
        m_bvalid_i   = 1'b0;
        m_bresp_i    = 2'b00;
        resp_ready_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int k, ar_seen, ar_hs, aw_cyc, aw_hs, w_cyc, w_hs, b_cnt, rv_seen;
        bit done;
        lsu_resp_t e;
        k = 0; ar_seen = 0; ar_hs = 0; aw_cyc = 0; aw_hs = 0; w_cyc = 0; w_hs = 0; b_cnt = 0; rv_seen = 0;
        done = 1'b0;
        @(negedge clk);
        clear_slave();
        req_valid_i      = 1'b1;
        req_load_type_i  = v.lt;
        req_store_type_i = v.st;
        req_addr_i       = v.addr;
        req_wdata_i      = v.wdata;
        chk({tag, ".req_ready_idle"}, {31'h0, req_ready_o}, 32'h1);
        exp_q.push_back('{data: v.exp_data, err: v.exp_err});
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            req_valid_i = 1'b0;
            clear_slave();
            if (m_arvalid_o) begin
                ar_seen++;
                if (ar_seen > v.ar_wait) begin
                    m_arready_i = 1'b1;
                    ar_hs++;
                    chk({tag, ".araddr"}, m_araddr_o, v.exp_bus_addr);
                end
            end
            if (m_rready_o) begin
                m_rvalid_i = 1'b1;
                m_rdata_i  = v.rdata;
                m_rresp_i  = v.rresp;
            end
            if (m_awvalid_o) begin
                aw_cyc++;
                if (aw_cyc > v.aw_wait) begin
                    m_awready_i = 1'b1;
                    aw_hs++;
                    chk({tag, ".awaddr"}, m_awaddr_o, v.exp_bus_addr);
                end
            end
            if (m_wvalid_o) begin
                w_cyc++;
                if (w_cyc > v.w_wait) begin
                    m_wready_i = 1'b1;
                    w_hs++;
                    chk({tag, ".wdata"}, m_wdata_o, v.exp_wdata);
                    chk({tag, ".wstrb"}, {28'h0, m_wstrb_o}, {28'h0, v.exp_wstrb});
                end
            end
            if (m_bready_o) begin
                m_bvalid_i = 1'b1;
                m_bresp_i  = v.bresp;
                b_cnt++;
            end
            if (resp_valid_o) begin
                rv_seen++;
                if (rv_seen == 1 && v.exp_lat != 0)
                    chk({tag, ".latency"}, k, v.exp_lat);
                chk({tag, ".req_ready_busy"}, {31'h0, req_ready_o}, 32'h0);
                chk({tag, ".data_held"}, resp_data_o, v.exp_data);
                chk({tag, ".err_held"}, {31'h0, resp_err_o}, {31'h0, v.exp_err});
                if (rv_seen > v.rr_wait) begin
                    resp_ready_i = 1'b1;
                    done = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk({tag, ".sb_empty"}, 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk({tag, ".resp_data"}, resp_data_o, e.data);
                        chk({tag, ".resp_err"}, {31'h0, resp_err_o}, {31'h0, e.err});
                    end
                end
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s.timeout: no response after %0d cycles", tag, k);
            exp_q.delete();
        end
        @(negedge clk);
        clear_slave();
        chk({tag, ".resp_valid_drop"}, {31'h0, resp_valid_o}, 32'h0);
        chk({tag, ".back_to_idle"}, {31'h0, req_ready_o}, 32'h1);
        chk({tag, ".ar_count"}, ar_hs, v.exp_rd ? 1 : 0);
        chk({tag, ".aw_count"}, aw_hs, v.exp_wr ? 1 : 0);
        chk({tag, ".w_count"}, w_hs, v.exp_wr ? 1 : 0);
        chk({tag, ".b_count"}, b_cnt, v.exp_wr ? 1 : 0);
        chk({tag, ".awvalid_cycles"}, aw_cyc, v.exp_wr ? v.aw_wait + 1 : 0);
        chk({tag, ".wvalid_cycles"}, w_cyc, v.exp_wr ? v.w_wait + 1 : 0);
    endtask

    task automatic reset_mid_read();
        int k;
        bit hit;
        k = 0;
        hit = 1'b0;
        @(negedge clk);
        clear_slave();
        req_valid_i      = 1'b1;
        req_load_type_i  = LOAD_LW;
        req_store_type_i = STORE_NONE;
        req_addr_i       = 32'h00000200;
        exp_q.push_back('{data: 32'h0, err: 1'b0});
        while (!hit && k < 20) begin
            @(negedge clk);
            k++;
            req_valid_i = 1'b0;
            clear_slave();
            if (m_arvalid_o) m_arready_i = 1'b1;
            if (m_rready_o) begin
                rst_n = 1'b0;
                hit   = 1'b1;
            end
        end
        if (!hit) begin
            n_checks++;
            $display("FAIL rst.timeout: never reached read data phase");
        end
        exp_q.delete();
        @(negedge clk);
        chk("rst.arvalid", {31'h0, m_arvalid_o}, 32'h0);
        chk("rst.rready", {31'h0, m_rready_o}, 32'h0);
        chk("rst.awvalid", {31'h0, m_awvalid_o}, 32'h0);
        chk("rst.wvalid", {31'h0, m_wvalid_o}, 32'h0);
        chk("rst.bready", {31'h0, m_bready_o}, 32'h0);
        chk("rst.resp_valid", {31'h0, resp_valid_o}, 32'h0);
        chk("rst.resp_data", resp_data_o, 32'h0);
        chk("rst.resp_err", {31'h0, resp_err_o}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.idle_ready", {31'h0, req_ready_o}, 32'h1);
        chk("rst.idle_rready", {31'h0, m_rready_o}, 32'h0);
    endtask

    initial begin
        rst_n            = 1'b0;
        req_valid_i      = 1'b0;
        req_load_type_i  = LOAD_NONE;
        req_store_type_i = STORE_NONE;
        req_addr_i       = 32'h0;
        req_wdata_i      = 32'h0;
        clear_slave();

        vecs.push_back(rd_vec(LOAD_LW,  STORE_NONE, 32'h80000004, 32'hDEADBEEF, 2'b00, 0, 0, 32'hDEADBEEF, 1'b0));
        vecs.push_back(rd_vec(LOAD_LB,  STORE_NONE, 32'h80000003, 32'h80112233, 2'b00, 0, 0, 32'hFFFFFF80, 1'b0));
        vecs.push_back(rd_vec(LOAD_LBU, STORE_NONE, 32'h80000003, 32'h80112233, 2'b00, 0, 0, 32'h00000080, 1'b0));
        vecs.push_back(wr_vec(STORE_SH, 32'h80000002, 32'h0000ABCD, 2'b00, 0, 0, 32'hABCD0000, 4'b1100, 1'b0));
        vecs.push_back(wr_vec(STORE_SW, 32'h40000010, 32'h12345678, 2'b00, 2, 0, 32'h12345678, 4'b1111, 1'b0));
        vecs.push_back(rd_vec(LOAD_LH,  STORE_NONE, 32'h80000000, 32'h1234F00D, 2'b10, 0, 5, 32'hFFFFF00D, 1'b1));
        vecs.push_back(rd_vec(LOAD_LHU, STORE_NONE, 32'h00000102, 32'h80010000, 2'b00, 2, 0, 32'h00008001, 1'b0));
        vecs.push_back(wr_vec(STORE_SB, 32'h00000021, 32'h000000A5, 2'b11, 0, 0, 32'h0000A500, 4'b0010, 1'b1));
        vecs.push_back(rd_vec(LOAD_LD,  STORE_NONE, 32'h00000008, 32'hCAFEF00D, 2'b00, 0, 0, 32'hCAFEF00D, 1'b0));
        vecs.push_back(rd_vec(LOAD_LWU, STORE_NONE, 32'h00000010, 32'h89ABCDEF, 2'b00, 0, 0, 32'h89ABCDEF, 1'b0));
        vecs.push_back(wr_vec(STORE_SD, 32'h0000000C, 32'h01020304, 2'b00, 0, 2, 32'h01020304, 4'b1111, 1'b0));
        vecs.push_back(nobus_vec(LOAD_NONE, STORE_NONE, 32'h00000040, 1'b0));
        vecs.push_back(rd_vec(LOAD_LBU, STORE_SW, 32'h00000001, 32'h00007F00, 2'b00, 0, 0, 32'h0000007F, 1'b0));
`ifdef LIANG_LSU_MISALIGN_CHK_EN
        vecs.push_back(nobus_vec(LOAD_LW,   STORE_NONE, 32'h80000002, 1'b1));
        vecs.push_back(nobus_vec(LOAD_NONE, STORE_SW,   32'h00000003, 1'b1));
        vecs.push_back(nobus_vec(LOAD_NONE, STORE_SH,   32'h00000003, 1'b1));
        vecs.push_back(nobus_vec(LOAD_LH,   STORE_NONE, 32'h30000003, 1'b1));
`else
        vecs.push_back(rd_vec(LOAD_LW, STORE_NONE, 32'h80000002, 32'hAABBCCDD, 2'b00, 0, 0, 32'h0000AABB, 1'b0));
        vecs.push_back(wr_vec(STORE_SW, 32'h00000003, 32'h11223344, 2'b00, 0, 0, 32'h44000000, 4'b1111, 1'b0));
        vecs.push_back(wr_vec(STORE_SH, 32'h00000003, 32'h0000BEEF, 2'b00, 0, 0, 32'hEF000000, 4'b1000, 1'b0));
        vecs.push_back(rd_vec(LOAD_LH, STORE_NONE, 32'h30000003, 32'h8899AABB, 2'b00, 0, 0, 32'h00000088, 1'b0));
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.req_ready", {31'h0, req_ready_o}, 32'h0);
        chk("reset.arvalid", {31'h0, m_arvalid_o}, 32'h0);
        chk("reset.awvalid", {31'h0, m_awvalid_o}, 32'h0);
        chk("reset.resp_valid", {31'h0, resp_valid_o}, 32'h0);
        chk("reset.resp_data", resp_data_o, 32'h0);
        chk("reset.resp_err", {31'h0, resp_err_o}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        reset_mid_read();
        run_vec(vecs[0], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/liang_lsu.md
Name: liang_lsu

Overview:
- Load/store unit in the EX stage. Accepts one memory uop per handshake from the EX datapath, runs one AXI4-Lite master transaction, and aligns/extends the read data.
- Returns the result that fills the exToWb_t lsu_res field.
- Single outstanding access; the pipeline stalls on req_ready_o.

Parameters:
ADDR_WIDTH, 32, AXI address width (from liang_pkg)
DATA_WIDTH, 32, AXI data width (from liang_pkg)
STRB_WIDTH, DATA_WIDTH/8, write strobe width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
req_valid_i  in  1  EX presents a memory uop
req_ready_o  out  1  LSU can accept a uop (IDLE only)
req_load_type_i  in  3  load_type_e
req_store_type_i  in  3  store_type_e
req_addr_i  in  32  effective address (rs1+imm)
req_wdata_i  in  32  store data (rs2)
resp_valid_o  out  1  result available
resp_ready_i  in  1  WB side accepts result
resp_data_o  out  32  extended load data; 0 for stores
resp_err_o  out  1  bus or alignment error
m_araddr_o/m_arvalid_o/m_arready_i  out/out/in  32/1/1  AXI-Lite AR
m_rdata_i/m_rresp_i/m_rvalid_i/m_rready_o  in/in/in/out  32/2/1/1  AXI-Lite R
m_awaddr_o/m_awvalid_o/m_awready_i  out/out/in  32/1/1  AXI-Lite AW
m_wdata_o/m_wstrb_o/m_wvalid_i... m_wvalid_o/m_wready_i  out/out/out/in  32/4/1/1  AXI-Lite W
m_bresp_i/m_bvalid_i/m_bready_o  in/in/out  2/1/1  AXI-Lite B

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE.
  - All valid, ready and bready outputs go to 0; resp_data_o and resp_err_o go to 0.
  - Reset mid-transaction abandons the transaction; the memory is reset by the same reset.
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch type, offset addr[1:0] and wdata.
  - Load type != LOAD_NONE goes to RD_ADDR. This takes priority if both types are set.
  - Else store type != STORE_NONE goes to WR.
  - Else (both NONE) goes to RESP with data 0, err 0.
- RD_ADDR: m_arvalid_o=1, m_araddr_o={addr[31:2],2'b00}, held stable. Goes to RD_DATA on arready.
- RD_DATA:
  - m_rready_o=1.
  - On rvalid, shift rdata right by 8*offset.
  - Extend per type: LB/LBU byte, LH/LHU half, LW/LD/LWU full word. LD and LWU are treated as LW since XLEN=32.
  - err = (rresp != 2'b00). Goes to RESP.
- WR:
  - awvalid and wvalid both assert in the first cycle.
  - Each channel deasserts independently once its handshake completes; aw_done and w_done flags are tracked.
  - Goes to WR_RESP when both are done; this may happen in the same cycle.
  - wdata = store data shifted left by 8*offset.
  - wstrb: SB 4'b0001<<offset; SH 4'b0011<<offset; SW/SD 4'b1111.
- WR_RESP: bready=1. On bvalid, err = (bresp != 0), data = 0. Goes to RESP.
- RESP:
  - resp_valid_o=1; data and err held stable.
  - On resp_ready_i goes to IDLE. No new request is accepted in that same cycle.
- Latency:
  - Request accepted at cycle N gives arvalid/awvalid at N+1.
  - With a zero-wait slave, resp_valid_o at N+3.
- Minimum 4 cycles per op.
- AXI rule: valid signals never drop before their handshake completes.

Optional Feature:
- Macro LIANG_LSU_MISALIGN_CHK_EN.
- When defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issues no bus transaction.
  - IDLE goes directly to RESP with err=1, data=0.
- When undefined:
  - Misaligned accesses are issued.
  - Lanes beyond byte 3 are dropped: shifted strobe bits above 3 are truncated and read data is zero-filled before extension.
  - resp_err_o reflects bus responses only.

Decomposition:
- liang_pkg gains:
  - lsu_state_e enum.
  - Typedefs lsu_req_t {load_type, store_type, addr, wdata} and lsu_resp_t {data, err}.
  - Constant AXI_RESP_OKAY=2'b00.
- Existing load_type_e, store_type_e, ADDR_WIDTH, DATA_WIDTH and STRB_WIDTH are reused.
- Sub-module liang_lsu_align: combinational read extract/extend plus write shift/strobe generation. The FSM stays in liang_lsu.

Test Plan:
- LW addr 0x80000004, slave returns 0xDEADBEEF with OKAY → araddr 0x80000004; resp_data 0xDEADBEEF at N+3, err 0.
- LB addr 0x80000003, rdata 0x80112233 → araddr 0x80000000; data 0xFFFFFF80. LBU at the same address gives 0x00000080.
- SH addr 0x80000002, wdata 0x0000ABCD → wdata 0xABCD0000, wstrb 4'b1100, data 0.
- SW with awready delayed 3 cycles and wready immediate → wvalid drops after 1 cycle, awvalid holds 3 cycles, one B, resp_valid once.
- Load with rresp=2'b10, resp_ready_i low 5 cycles → resp_valid and err=1 held stable 5 cycles; req_ready_o stays 0 throughout.
- rst_n low during RD_DATA → next cycle IDLE, all valids 0. With LIANG_LSU_MISALIGN_CHK_EN, LW at 0x...2 gives no arvalid and err=1.
